// File: rtl/sys_bus_arbiter_if.sv
// Bus bundle for sys_bus_arbiter: two master ports plus the shared slave bus.
// The "slave" modport is the arbiter's view (it serves the masters and drives
// the slaves); the "master" modport is the surrounding system's view.
interface sys_bus_arbiter_if #(
  parameter int unsigned NUM_SLAVES = 8
);
  // Master 0 (core data port)
  logic                       m0_req_i;
  logic                       m0_we_i;
  logic [31:0]                m0_addr_i;
  logic [31:0]                m0_wd_i;
  logic [3:0]                 m0_be_i;
  logic [31:0]                m0_rd_o;
  logic                       m0_ready_o;
  logic                       m0_err_o;
  logic                       m0_stall_o;

  // Master 1 (DMA / loader)
  logic                       m1_req_i;
  logic                       m1_we_i;
  logic [31:0]                m1_addr_i;
  logic [31:0]                m1_wd_i;
  logic [3:0]                 m1_be_i;
  logic [31:0]                m1_rd_o;
  logic                       m1_ready_o;
  logic                       m1_err_o;
  logic                       m1_stall_o;

  // Shared slave bus
  logic [NUM_SLAVES-1:0]      s_req_o;
  logic                       s_we_o;
  logic [31:0]                s_addr_o;
  logic [31:0]                s_wd_o;
  logic [3:0]                 s_be_o;
  logic [NUM_SLAVES*32-1:0]   s_rd_i;
  logic [NUM_SLAVES-1:0]      s_ready_i;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wd_i, m0_be_i,
    output m0_rd_o, m0_ready_o, m0_err_o, m0_stall_o,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wd_i, m1_be_i,
    output m1_rd_o, m1_ready_o, m1_err_o, m1_stall_o,
    output s_req_o, s_we_o, s_addr_o, s_wd_o, s_be_o,
    input  s_rd_i, s_ready_i
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wd_i, m0_be_i,
    input  m0_rd_o, m0_ready_o, m0_err_o, m0_stall_o,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wd_i, m1_be_i,
    input  m1_rd_o, m1_ready_o, m1_err_o, m1_stall_o,
    input  s_req_o, s_we_o, s_addr_o, s_wd_o, s_be_o,
    output s_rd_i, s_ready_i
  );
endinterface

// File: rtl/sys_bus_arbiter.sv
// Two-master round-robin system-bus controller with addr[31:24] slave decode.
// One transaction at a time: IDLE (arbitrate/decode) -> ACCESS (wait slave
// ready) -> DONE (one-cycle completion pulse to the granted master).
// Optional macro BUS_TIMEOUT_EN adds an ACCESS watchdog that completes with
// ERR_DATA and err after TIMEOUT_CYCLES cycles without slave ready; without
// it ACCESS waits indefinitely and TIMEOUT_CYCLES does not exist.
module sys_bus_arbiter #(
  parameter int unsigned NUM_SLAVES     = 8,
`ifdef BUS_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 255,
`endif
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic               clk_i,
  input  logic               resetn_i,
  sys_bus_arbiter_if.slave   bus
);

  localparam int unsigned DW    = 32;
  localparam int unsigned BEW   = 4;
  localparam int unsigned SEL_W = 8;
`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TO_W  = ($clog2(TIMEOUT_CYCLES) < 8) ? 8 : $clog2(TIMEOUT_CYCLES);
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;   // 1: m1 was served last
  logic                  gnt_q, gnt_d;                 // 1: m1 owns the bus
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [NUM_SLAVES-1:0] s_req_q, s_req_d;
  logic                  s_we_q, s_we_d;
  logic [DW-1:0]         s_addr_q, s_addr_d;
  logic [DW-1:0]         s_wd_q, s_wd_d;
  logic [BEW-1:0]        s_be_q, s_be_d;
  logic [DW-1:0]         m0_rd_q, m0_rd_d, m1_rd_q, m1_rd_d;
  logic                  m0_ready_q, m0_ready_d, m1_ready_q, m1_ready_d;
  logic                  m0_err_q, m0_err_d, m1_err_q, m1_err_d;
`ifdef BUS_TIMEOUT_EN
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
`endif

  // Winner-side request fields and decode
  logic                  pick_m1;
  logic                  req_we;
  logic [DW-1:0]         req_addr;
  logic [DW-1:0]         req_wd;
  logic [BEW-1:0]        req_be;
  logic [SEL_W-1:0]      req_sel;
  logic                  req_mapped;

  // Selected-slave response
  logic                  sel_ready;
  logic [DW-1:0]         sel_rd;

  // Completion payload routed to the granted master
  logic                  cpl;
  logic [DW-1:0]         cpl_rd;
  logic                  cpl_err;

  // Round-robin pick: on a tie the master that was not served last wins
  always_comb begin
    pick_m1 = bus.m1_req_i;
    if (bus.m0_req_i && bus.m1_req_i) begin
      pick_m1 = ~last_grant_q;
    end
    req_we     = pick_m1 ? bus.m1_we_i   : bus.m0_we_i;
    req_addr   = pick_m1 ? bus.m1_addr_i : bus.m0_addr_i;
    req_wd     = pick_m1 ? bus.m1_wd_i   : bus.m0_wd_i;
    req_be     = pick_m1 ? bus.m1_be_i   : bus.m0_be_i;
    req_sel    = req_addr[31:24];
    req_mapped = {24'b0, req_sel} < NUM_SLAVES;
  end

  // Mux ready and read data of the latched slave index
  always_comb begin
    sel_ready = 1'b0;
    sel_rd    = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_ready = bus.s_ready_i[i];
        sel_rd    = bus.s_rd_i[DW*i +: DW];
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    sel_d        = sel_q;
    s_req_d      = s_req_q;
    s_we_d       = s_we_q;
    s_addr_d     = s_addr_q;
    s_wd_d       = s_wd_q;
    s_be_d       = s_be_q;
    m0_rd_d      = '0;
    m1_rd_d      = '0;
    m0_ready_d   = 1'b0;
    m1_ready_d   = 1'b0;
    m0_err_d     = 1'b0;
    m1_err_d     = 1'b0;
    cpl          = 1'b0;
    cpl_rd       = '0;
    cpl_err      = 1'b0;
`ifdef BUS_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.m0_req_i || bus.m1_req_i) begin
          gnt_d        = pick_m1;
          last_grant_d = pick_m1;
          sel_d        = req_sel;
          s_we_d       = req_we;
          s_addr_d     = req_addr;
          s_wd_d       = req_wd;
          s_be_d       = req_be;
          if (req_mapped) begin
            state_d = ACCESS;
            for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
              s_req_d[i] = (req_sel == SEL_W'(i));
            end
`ifdef BUS_TIMEOUT_EN
            to_cnt_d = '0;
`endif
          end else begin
            // Decode error: answer directly without touching any slave
            state_d = DONE;
            cpl     = 1'b1;
            cpl_rd  = ERR_DATA;
            cpl_err = 1'b1;
          end
        end
      end

      ACCESS: begin
        if (sel_ready) begin
          state_d = DONE;
          s_req_d = '0;
          cpl     = 1'b1;
          cpl_rd  = s_we_q ? '0 : sel_rd;
        end
`ifdef BUS_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          s_req_d = '0;
          cpl     = 1'b1;
          cpl_rd  = ERR_DATA;
          cpl_err = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        s_req_d = '0;
      end
    endcase

    // Completion is presented during DONE, so it is loaded on the way in
    if (cpl) begin
      if (gnt_d) begin
        m1_ready_d = 1'b1;
        m1_rd_d    = cpl_rd;
        m1_err_d   = cpl_err;
      end else begin
        m0_ready_d = 1'b1;
        m0_rd_d    = cpl_rd;
        m0_err_d   = cpl_err;
      end
    end
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      sel_q        <= '0;
      s_req_q      <= '0;
      s_we_q       <= 1'b0;
      s_addr_q     <= '0;
      s_wd_q       <= '0;
      s_be_q       <= '0;
      m0_rd_q      <= '0;
      m1_rd_q      <= '0;
      m0_ready_q   <= 1'b0;
      m1_ready_q   <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      sel_q        <= sel_d;
      s_req_q      <= s_req_d;
      s_we_q       <= s_we_d;
      s_addr_q     <= s_addr_d;
      s_wd_q       <= s_wd_d;
      s_be_q       <= s_be_d;
      m0_rd_q      <= m0_rd_d;
      m1_rd_q      <= m1_rd_d;
      m0_ready_q   <= m0_ready_d;
      m1_ready_q   <= m1_ready_d;
      m0_err_q     <= m0_err_d;
      m1_err_q     <= m1_err_d;
`ifdef BUS_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

  assign bus.s_req_o    = s_req_q;
  assign bus.s_we_o     = s_we_q;
  assign bus.s_addr_o   = s_addr_q;
  assign bus.s_wd_o     = s_wd_q;
  assign bus.s_be_o     = s_be_q;
  assign bus.m0_rd_o    = m0_rd_q;
  assign bus.m1_rd_o    = m1_rd_q;
  assign bus.m0_ready_o = m0_ready_q;
  assign bus.m1_ready_o = m1_ready_q;
  assign bus.m0_err_o   = m0_err_q;
  assign bus.m1_err_o   = m1_err_q;

  // Stall is combinational so the core freezes from the very request cycle
  assign bus.m0_stall_o = bus.m0_req_i & ~m0_ready_q;
  assign bus.m1_stall_o = bus.m1_req_i & ~m1_ready_q;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Directed bench for sys_bus_arbiter: table of single-master transactions
// plus hand-written round-robin, timeout/indefinite-wait and reset sequences.
module tb_sys_bus_arbiter;

  localparam int unsigned NS = 8;
`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TO = 4;
`endif

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  sys_bus_arbiter_if #(.NUM_SLAVES(NS)) bus ();

  sys_bus_arbiter #(
    .NUM_SLAVES(NS),
`ifdef BUS_TIMEOUT_EN
    .TIMEOUT_CYCLES(TO),
`endif
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk_i   (clk),
    .resetn_i(resetn),
    .bus     (bus)
  );

  typedef struct {
    logic          mst;
    logic          we;
    logic [31:0]   addr;
    logic [31:0]   wd;
    logic [3:0]    be;
    int            dly;      // ACCESS cycle on which the slave is ready (0 = never)
    logic          noise;    // assert ready on every non-selected slave
    logic [31:0]   sdata;
    int            exp_lat;  // cycles from request to ready pulse
    int            exp_acc;  // cycles with s_req_o high
    logic [NS-1:0] exp_sreq;
    logic [31:0]   exp_rd;
    logic          exp_err;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   rdy_delay = 0;
  logic noise_en = 1'b0;
  int   acc_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock; then update the slave responder from the new bus state
  task automatic cycle();
    logic [NS-1:0] rdy;
    @(posedge clk);
    #1;
    if (bus.s_req_o != '0) acc_cnt++;
    else acc_cnt = 0;
    rdy = '0;
    for (int i = 0; i < int'(NS); i++) begin
      if (bus.s_req_o[i] && rdy_delay != 0 && acc_cnt >= rdy_delay) rdy[i] = 1'b1;
    end
    if (noise_en) rdy = rdy | ~bus.s_req_o;
    bus.s_ready_i = rdy;
  endtask

  task automatic drive(input logic m, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    if (m) begin
      bus.m1_req_i = req; bus.m1_we_i = we; bus.m1_addr_i = addr;
      bus.m1_wd_i = wd; bus.m1_be_i = be;
    end else begin
      bus.m0_req_i = req; bus.m0_we_i = we; bus.m0_addr_i = addr;
      bus.m0_wd_i = wd; bus.m0_be_i = be;
    end
  endtask

  task automatic set_req(input logic m, input logic req);
    if (m) bus.m1_req_i = req;
    else bus.m0_req_i = req;
  endtask

  function automatic logic m_ready(input logic m);
    return m ? bus.m1_ready_o : bus.m0_ready_o;
  endfunction

  function automatic logic m_err(input logic m);
    return m ? bus.m1_err_o : bus.m0_err_o;
  endfunction

  function automatic logic m_stall(input logic m);
    return m ? bus.m1_stall_o : bus.m0_stall_o;
  endfunction

  function automatic logic [31:0] m_rd(input logic m);
    return m ? bus.m1_rd_o : bus.m0_rd_o;
  endfunction

  task automatic fill_sdata(input logic [31:0] addr, input logic [31:0] d);
    for (int i = 0; i < int'(NS); i++) bus.s_rd_i[32*i +: 32] = 32'hBAD0_0000 | 32'(i);
    if (int'(addr[31:24]) < int'(NS)) bus.s_rd_i[32*int'(addr[31:24]) +: 32] = d;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rdy_delay = 0;
    noise_en  = 1'b0;
    bus.s_ready_i = '0;
    resetn = 1'b0;
    cycle();
    cycle();
    resetn = 1'b1;
    cycle();
  endtask

  // Run one transaction from IDLE and compare against the vector
  task automatic run_txn(input vec_t v, input string tag);
    int          lat = 0;
    int          acc = 0;
    logic        seen = 1'b0;
    logic [31:0] rd = 'x;
    logic        err = 1'bx;
    logic        fields_ok = 1'b1;
    logic        stall_ok = 1'b1;
    logic        other_ok = 1'b1;
    rdy_delay = v.dly;
    noise_en  = v.noise;
    acc_cnt   = 0;
    fill_sdata(v.addr, v.sdata);
    drive(v.mst, 1'b1, v.we, v.addr, v.wd, v.be);
    #1;
    if (m_stall(v.mst) !== 1'b1) stall_ok = 1'b0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      cycle();
      if (bus.s_req_o != '0) begin
        acc++;
        if (bus.s_req_o !== v.exp_sreq || bus.s_we_o !== v.we || bus.s_addr_o !== v.addr ||
            bus.s_wd_o !== v.wd || bus.s_be_o !== v.be) fields_ok = 1'b0;
      end
      if (m_ready(~v.mst) !== 1'b0) other_ok = 1'b0;
      if (m_ready(v.mst) === 1'b1) begin
        seen = 1'b1;
        lat  = c;
        rd   = m_rd(v.mst);
        err  = m_err(v.mst);
        if (m_stall(v.mst) !== 1'b0) stall_ok = 1'b0;
        set_req(v.mst, 1'b0);
      end else if (m_stall(v.mst) !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, " s_req cycles"}, 32'(acc), 32'(v.exp_acc));
    check({tag, " rd"}, rd, v.exp_rd);
    check({tag, " err"}, 32'(err), 32'(v.exp_err));
    check({tag, " bus fields"}, 32'(fields_ok), 32'd1);
    check({tag, " stall"}, 32'(stall_ok), 32'd1);
    check({tag, " other master quiet"}, 32'(other_ok), 32'd1);
    cycle();
    check({tag, " post rd"}, m_rd(v.mst), 32'h0);
    check({tag, " post flags"}, {30'b0, m_ready(v.mst), m_err(v.mst)}, 32'h0);
  endtask

  vec_t vecs[9];

  initial begin
    logic        order[$];
    int          rem0, rem1;
    logic        re0, re1;
    int          hi, pulses, lat;
    logic        ok;
    logic [31:0] rd;

    vecs[0] = '{mst:1'b0, we:1'b0, addr:32'h0000_0040, wd:32'h0, be:4'hF, dly:2, noise:1'b0,
                sdata:32'h1234_5678, exp_lat:3, exp_acc:2, exp_sreq:8'h01, exp_rd:32'h1234_5678, exp_err:1'b0};
    vecs[1] = '{mst:1'b1, we:1'b1, addr:32'h0400_0010, wd:32'hA5A5_0001, be:4'h3, dly:1, noise:1'b0,
                sdata:32'h5555_AAAA, exp_lat:2, exp_acc:1, exp_sreq:8'h10, exp_rd:32'h0, exp_err:1'b0};
    vecs[2] = '{mst:1'b0, we:1'b0, addr:32'h2000_0000, wd:32'h0, be:4'hF, dly:1, noise:1'b0,
                sdata:32'h0, exp_lat:1, exp_acc:0, exp_sreq:8'h00, exp_rd:32'hDEAD_BEEF, exp_err:1'b1};
    vecs[3] = '{mst:1'b1, we:1'b0, addr:32'h0700_FFFC, wd:32'h0, be:4'hF, dly:3, noise:1'b1,
                sdata:32'hCAFE_F00D, exp_lat:4, exp_acc:3, exp_sreq:8'h80, exp_rd:32'hCAFE_F00D, exp_err:1'b0};
    vecs[4] = '{mst:1'b0, we:1'b0, addr:32'h0800_0000, wd:32'h0, be:4'hF, dly:1, noise:1'b0,
                sdata:32'h0, exp_lat:1, exp_acc:0, exp_sreq:8'h00, exp_rd:32'hDEAD_BEEF, exp_err:1'b1};
    vecs[5] = '{mst:1'b1, we:1'b1, addr:32'hFF00_0000, wd:32'h1111_2222, be:4'hC, dly:1, noise:1'b0,
                sdata:32'h0, exp_lat:1, exp_acc:0, exp_sreq:8'h00, exp_rd:32'hDEAD_BEEF, exp_err:1'b1};
    vecs[6] = '{mst:1'b0, we:1'b1, addr:32'h0300_0004, wd:32'h0BAD_F00D, be:4'hF, dly:1, noise:1'b1,
                sdata:32'h7777_7777, exp_lat:2, exp_acc:1, exp_sreq:8'h08, exp_rd:32'h0, exp_err:1'b0};
    vecs[7] = '{mst:1'b0, we:1'b0, addr:32'h0200_0000, wd:32'h0, be:4'h1, dly:1, noise:1'b1,
                sdata:32'h0F0F_0F0F, exp_lat:2, exp_acc:1, exp_sreq:8'h04, exp_rd:32'h0F0F_0F0F, exp_err:1'b0};
    vecs[8] = '{mst:1'b1, we:1'b0, addr:32'h06FF_FFFF, wd:32'h0, be:4'h8, dly:2, noise:1'b0,
                sdata:32'h6666_0006, exp_lat:3, exp_acc:2, exp_sreq:8'h40, exp_rd:32'h6666_0006, exp_err:1'b0};

    bus.s_rd_i    = '0;
    bus.s_ready_i = '0;
    do_reset();

    // Reset state
    check("reset s_req", 32'(bus.s_req_o), 32'h0);
    check("reset s_addr", bus.s_addr_o, 32'h0);
    check("reset s_wd", bus.s_wd_o, 32'h0);
    check("reset s_we/be", {27'b0, bus.s_we_o, bus.s_be_o}, 32'h0);
    check("reset m0_rd", bus.m0_rd_o, 32'h0);
    check("reset m1_rd", bus.m1_rd_o, 32'h0);
    check("reset flags", {26'b0, bus.m0_ready_o, bus.m0_err_o, bus.m0_stall_o,
                          bus.m1_ready_o, bus.m1_err_o, bus.m1_stall_o}, 32'h0);

    // Table of single-master transactions
    for (int i = 0; i < 9; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Round robin: simultaneous requests after reset, each master twice
    do_reset();
    for (int i = 0; i < int'(NS); i++) bus.s_rd_i[32*i +: 32] = 32'h1000_0000 + 32'(i);
    rdy_delay = 1;
    drive(1'b0, 1'b1, 1'b0, 32'h0100_0000, 32'h0, 4'hF);
    drive(1'b1, 1'b1, 1'b0, 32'h0200_0000, 32'h0, 4'hF);
    rem0 = 2; rem1 = 2; re0 = 1'b0; re1 = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      cycle();
      if (re0) begin bus.m0_req_i = 1'b1; re0 = 1'b0; end
      if (re1) begin bus.m1_req_i = 1'b1; re1 = 1'b0; end
      if (bus.m0_ready_o && bus.m1_ready_o) ok = 1'b0;
      if (bus.m0_ready_o === 1'b1) begin
        order.push_back(1'b0);
        if (bus.m0_rd_o !== 32'h1000_0001) ok = 1'b0;
        rem0--; bus.m0_req_i = 1'b0; re0 = (rem0 > 0);
      end else if (bus.m1_ready_o === 1'b1) begin
        order.push_back(1'b1);
        if (bus.m1_rd_o !== 32'h1000_0002) ok = 1'b0;
        rem1--; bus.m1_req_i = 1'b0; re1 = (rem1 > 0);
      end
    end
    check("rr grant count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr order[%0d]", i), (i < order.size()) ? 32'(order[i]) : 32'd9, 32'(i % 2));
    end
    check("rr read data", 32'(ok), 32'd1);
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      if (bus.m0_ready_o || bus.m1_ready_o) pulses++;
    end
    check("rr no extra pulses", 32'(pulses), 32'd0);

    // Slave 3 never answers
    do_reset();
`ifdef BUS_TIMEOUT_EN
    run_txn('{mst:1'b0, we:1'b0, addr:32'h0300_0000, wd:32'h0, be:4'hF, dly:0, noise:1'b0,
              sdata:32'h3333_3333, exp_lat:5, exp_acc:4, exp_sreq:8'h08, exp_rd:32'hDEAD_BEEF,
              exp_err:1'b1}, "timeout");
`else
    fill_sdata(32'h0300_0000, 32'h3333_3333);
    rdy_delay = 0;
    drive(1'b0, 1'b1, 1'b0, 32'h0300_0000, 32'h0, 4'hF);
    hi = 0; pulses = 0; ok = 1'b1;
    for (int c = 0; c < 60; c++) begin
      cycle();
      if (bus.s_req_o === 8'h08) hi++;
      if (bus.m0_ready_o !== 1'b0) pulses++;
      if (bus.m0_stall_o !== 1'b1) ok = 1'b0;
    end
    check("wait s_req cycles", 32'(hi), 32'd60);
    check("wait no ready", 32'(pulses), 32'd0);
    check("wait stall held", 32'(ok), 32'd1);
    do_reset();
`endif

    // Reset while a transaction is in ACCESS
    do_reset();
    fill_sdata(32'h0500_0000, 32'h5A5A_0005);
    rdy_delay = 0;
    drive(1'b1, 1'b1, 1'b0, 32'h0500_0000, 32'h0, 4'hF);
    cycle();
    cycle();
    check("mid access s_req", 32'(bus.s_req_o), 32'h20);
    resetn = 1'b0;
    cycle();
    check("reset in access s_req", 32'(bus.s_req_o), 32'h0);
    check("reset in access flags", {30'b0, bus.m1_ready_o, bus.m1_err_o}, 32'h0);
    check("reset in access stall", 32'(bus.m1_stall_o), 32'd1);
    resetn = 1'b1;
    rdy_delay = 1;
    lat = 0; rd = 'x;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      cycle();
      if (bus.m1_ready_o === 1'b1) begin
        lat = c;
        rd  = bus.m1_rd_o;
        bus.m1_req_i = 1'b0;
      end
    end
    check("reserve latency", 32'(lat), 32'd2);
    check("reserve rd", rd, 32'h5A5A_0005);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sys_bus_arbiter.md
Name: sys_bus_arbiter

Overview:
- Shared system-bus controller between two bus masters and up to NUM_SLAVES memory-mapped slaves.
  - m0: core data port.
  - m1: secondary requester, e.g. DMA or UART program loader.
- Arbitrates the masters round-robin and decodes addr[31:24] into a one-hot slave request.
- Sequences one transaction at a time, waiting on per-slave ready, and returns read data plus a completion pulse to the granted master.
- Replaces the ad-hoc decode/read-mux in the top-level unit.

Parameters:
- NUM_SLAVES, 8: slave count; slave i is selected when addr[31:24] == i, for i < NUM_SLAVES.
- TIMEOUT_CYCLES, 255: ACCESS cycles allowed before an error response (only with BUS_TIMEOUT_EN).
- ERR_DATA, 32'hDEAD_BEEF: read data returned on a decode error or timeout.

Ports:
- clk_i  in  1  system clock
- resetn_i  in  1  synchronous active-low reset
- m0_req_i, m1_req_i  in  1  request; held stable until the matching ready pulse
- m0_we_i, m1_we_i  in  1  write enable
- m0_addr_i, m1_addr_i  in  32  byte address
- m0_wd_i, m1_wd_i  in  32  write data
- m0_be_i, m1_be_i  in  4  byte enables
- m0_rd_o, m1_rd_o  out  32  read data, valid while ready is high
- m0_ready_o, m1_ready_o  out  1  one-cycle completion pulse
- m0_err_o, m1_err_o  out  1  error flag, pulsed together with ready
- m0_stall_o, m1_stall_o  out  1  combinational req & ~ready, feeds core stall
- s_req_o  out  NUM_SLAVES  one-hot slave request
- s_we_o  out  1  write enable to slaves
- s_addr_o  out  32  address to slaves
- s_wd_o  out  32  write data to slaves
- s_be_o  out  4  byte enables to slaves
- s_rd_i  in  NUM_SLAVES*32  read data; slave i occupies bits [32*i+31:32*i]
- s_ready_i  in  NUM_SLAVES  per-slave ready

Behaviour:
- Reset (resetn_i low at a clock edge):
  - state goes to IDLE and last_grant = 1, so m0 wins the first tie.
  - All registered outputs clear to 0: s_req_o, s_we_o, s_addr_o, s_wd_o, s_be_o, m*_rd_o, m*_ready_o, m*_err_o.
  - A transaction in flight is abandoned: no ready pulse, s_req_o drops at that edge.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One master requesting: grant it.
  - Both requesting: grant the master != last_grant, then update last_grant.
  - On grant, latch we/addr/wd/be into bus registers and the selected slave index.
  - Mapped address (addr[31:24] < NUM_SLAVES): go to ACCESS.
  - Unmapped address: load rd = ERR_DATA, set err, go to DONE; no slave is requested.
- ACCESS:
  - s_req_o has the single bit for the selected slave set; all bus fields are held constant.
  - When s_ready_i[sel] = 1: capture s_rd_i slice sel (capture ignored on writes, rd = 0), go to DONE.
  - Ready from a non-selected slave is ignored.
- DONE:
  - Exactly one cycle; s_req_o = 0.
  - Granted master sees ready_o = 1 with rd_o and err_o.
  - rd_o and err_o return to 0 the next cycle; go to IDLE.
- Latency:
  - Request seen in IDLE at cycle 0; s_req_o high from cycle 1.
  - Slave ready at cycle k ≥ 1 gives the master ready pulse at cycle k+1.
  - Minimum is 3 cycles per transaction, back-to-back.
- Stall: m*_stall_o is combinational and stays high through IDLE and ACCESS until ready, so the core pipeline freezes with no gap.
- Non-granted master: its request stays pending, its stall stays high, and it is served at the next IDLE.
- Master dropping req mid-transaction: the transaction still completes; a stray ready pulse is permitted.

Optional Feature:
- BUS_TIMEOUT_EN defined:
  - An 8..16-bit counter clears on entry to ACCESS and increments each ACCESS cycle without ready.
  - When it reaches TIMEOUT_CYCLES-1 without ready: go to DONE with rd = ERR_DATA and err = 1.
  - Ready in the same cycle as the limit has priority and gives a normal completion.
- BUS_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for ready.

Test Plan:
- m0 read 0x0000_0040; slave0 ready on the 2nd ACCESS cycle with rd 0x1234_5678 -> s_req_o = 0x01 for 2 cycles; m0_ready_o pulses once with m0_rd_o = 0x1234_5678 and err = 0; m0_stall_o high until that pulse.
- m0 and m1 request in the same cycle after reset, then both request again -> order m0, m1, m0, m1; each master gets exactly one ready pulse per grant.
- m1 write to 0x0400_0010 with wd 0xA5A5_0001 and be 4'b0011; slave4 ready immediately -> s_req_o = 0x10, s_we_o = 1, s_wd_o = 0xA5A5_0001, s_be_o = 0x3; m1_ready_o 2 cycles after the request.
- m0 access to 0x2000_0000 (0x20 ≥ 8) -> s_req_o stays 0; m0_ready_o and m0_err_o pulse in cycle 1; m0_rd_o = 0xDEAD_BEEF.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES = 4, slave3 never ready -> s_req_o = 0x08 for exactly 4 cycles, then ready + err with rd = 0xDEAD_BEEF; without the macro, s_req_o stays high for 50+ cycles.
- resetn_i low for 1 cycle during ACCESS -> at that edge s_req_o = 0 and state = IDLE; no ready pulse; a request held high afterwards is re-served from IDLE.
